// File: rtl/sel_pipe_pkg.sv
// rtl/sel_pipe_pkg.sv - shared constants, occupancy width helper and stage record; parity field via SEL_PIPE_PARITY_EN
package sel_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam logic FILL_BIT = 1'b1;

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Stage record at the default width; the stage module rebuilds it at its own WIDTH.
   typedef struct packed {
      logic                 v;
      logic [DEF_WIDTH-1:0] d;
`ifdef SEL_PIPE_PARITY_EN
      logic                 p;
`endif
   } stage_t;

endpackage

// File: rtl/sel_pipe_reg_if.sv
// rtl/sel_pipe_reg_if.sv - upstream/downstream handshake bundle; par_err present with SEL_PIPE_PARITY_EN
interface sel_pipe_reg_if
   import sel_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic                      sel;
   logic [WIDTH-1:0]          din;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          dout;
   logic [occ_w(DEPTH)-1:0]   occ;
`ifdef SEL_PIPE_PARITY_EN
   logic                      par_err;

   modport master (output in_valid, sel, din, out_ready,
                   input  in_ready, out_valid, dout, occ, par_err);
   modport slave  (input  in_valid, sel, din, out_ready,
                   output in_ready, out_valid, dout, occ, par_err);
`else
   modport master (output in_valid, sel, din, out_ready,
                   input  in_ready, out_valid, dout, occ);
   modport slave  (input  in_valid, sel, din, out_ready,
                   output in_ready, out_valid, dout, occ);
`endif
endinterface

// File: rtl/sel_pipe_stage.sv
// rtl/sel_pipe_stage.sv - one valid/data register with load/hold/clear; parity bit via SEL_PIPE_PARITY_EN
module sel_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_d,
`ifdef SEL_PIPE_PARITY_EN
   input  logic             load_p,
   output logic             p,
`endif
   input  logic             nxt_free,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             adv
);
   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] d;
`ifdef SEL_PIPE_PARITY_EN
      logic             p;
`endif
   } st_t;

   st_t st_d, st_q;

   assign adv = st_q.v && nxt_free;

   // Load wins over drain so a simultaneous move-in/move-out keeps the stage full.
   always_comb begin
      st_d = st_q;
      if (load) begin
         st_d.v = 1'b1;
         st_d.d = load_d;
`ifdef SEL_PIPE_PARITY_EN
         st_d.p = load_p;
`endif
      end else if (adv) begin
         st_d.v = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= '0;
      else        st_q <= st_d;
   end

   assign v = st_q.v;
   assign d = st_q.d;
`ifdef SEL_PIPE_PARITY_EN
   assign p = st_q.p;
`endif
endmodule

// File: rtl/sel_pipe_reg.sv
// rtl/sel_pipe_reg.sv - elastic DEPTH-stage capture of din or FILL by sel; even parity check via SEL_PIPE_PARITY_EN
module sel_pipe_reg
   import sel_pipe_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] FILL  = {WIDTH{FILL_BIT}}
) (
   input logic           clk,
   input logic           reset,
   sel_pipe_reg_if.slave bus
);
   localparam int OCC_W = occ_w(DEPTH);

   logic             accept;
   logic             in_rdy;
   logic [WIDTH-1:0] cap;
   logic [DEPTH-1:0] v_all;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] ld;
   logic [DEPTH-1:0] nf;
   logic [WIDTH-1:0] d_all [DEPTH];
   logic [WIDTH-1:0] ld_d  [DEPTH];
   logic [OCC_W-1:0] occ_d, occ_q;

   assign cap    = bus.sel ? bus.din : FILL;
   assign in_rdy = reset && (!v_all[0] || nf[0]);
   assign accept = bus.in_valid && in_rdy;

   // nf[k]: whatever sits in stage k may leave this cycle; built from v only so the
   // ready chain never loops back through the stage outputs.
   always_comb begin
      logic f;
      f           = bus.out_ready;
      nf          = '0;
      nf[DEPTH-1] = f;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         f     = !v_all[k+1] || f;
         nf[k] = f;
      end
   end

   always_comb begin
      ld      = '0;
      ld[0]   = accept;
      ld_d[0] = cap;
      for (int k = 1; k < DEPTH; k++) begin
         ld[k]   = adv[k-1];
         ld_d[k] = d_all[k-1];
      end
   end

`ifdef SEL_PIPE_PARITY_EN
   logic [DEPTH-1:0] p_all;
   logic [DEPTH-1:0] ld_p;

   always_comb begin
      ld_p    = '0;
      ld_p[0] = ^cap;
      for (int k = 1; k < DEPTH; k++) ld_p[k] = p_all[k-1];
   end

   assign bus.par_err = v_all[DEPTH-1] && ((^d_all[DEPTH-1]) != p_all[DEPTH-1]);
`endif

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      sel_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .reset    (reset),
         .load     (ld[k]),
         .load_d   (ld_d[k]),
`ifdef SEL_PIPE_PARITY_EN
         .load_p   (ld_p[k]),
         .p        (p_all[k]),
`endif
         .nxt_free (nf[k]),
         .v        (v_all[k]),
         .d        (d_all[k]),
         .adv      (adv[k])
      );
   end

   always_comb occ_d = occ_q + OCC_W'(accept) - OCC_W'(adv[DEPTH-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) occ_q <= '0;
      else        occ_q <= occ_d;
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = v_all[DEPTH-1];
   assign bus.dout      = d_all[DEPTH-1];
   assign bus.occ       = occ_q;
endmodule

// File: doc/sel_pipe_reg.md
# sel_pipe_reg

Parametrised, elastic, multi-stage data register with per-beat source select. Each accepted beat captures either `din` or a fixed fill constant, selected by `sel`. The beat then travels through `DEPTH` valid/ready register stages. The block replaces single-bit select flops in the netlist test designs wherever multi-bit, stallable, deeper capture is needed.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 2: number of register stages, ≥1.
- `FILL`, all ones (`{WIDTH{1'b1}}`): value captured when `sel`=0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `sel`  in  1  1: capture `din`; 0: capture `FILL`. Sampled only on accept.
- `din`  in  WIDTH  input data.
- `out_valid`  out  1  last stage holds a beat.
- `out_ready`  in  1  downstream accepts.
- `dout`  out  WIDTH  last-stage data.
- `occ`  out  $clog2(DEPTH+1)  count of valid stages.
- `par_err`  out  1  present only with `SEL_PIPE_PARITY_EN`.

## Operation
- Accept condition: `in_valid && in_ready`.
- On accept, stage 0 loads `sel ? din : FILL`.
- Stage k holds `v[k]` and `d[k]`.
- Stage k advances into k+1 when `v[k] && (!v[k+1] || adv[k+1])`.
- The last stage advances when `out_ready`.
- `adv[k]` means stage k's content leaves this cycle.
- `in_ready = !v[0] || adv[0]`. This is combinational from `out_ready` through the chain, so full throughput is one beat per cycle.
- A stage that is not loaded and not drained holds its data and valid bit. Bubbles collapse: a beat moves forward whenever the next stage is empty, even while the output is stalled.
- `out_valid = v[DEPTH-1]`; `dout = d[DEPTH-1]`.
- `dout` is stable while `out_valid && !out_ready`.
- `occ` is the popcount of `v`, registered and updated the same edge as `v`.
- Reset (asserted, async):
  - all `v`=0 and all `d`=0, so `dout`=0, `out_valid`=0, `occ`=0.
  - `in_ready`=1 as soon as reset is released, not during reset.
- Reset mid-operation discards all in-flight beats with no partial output.
- Full condition: `occ`=DEPTH and `out_ready`=0 gives `in_ready`=0. With `out_ready`=1 in the same cycle, input is still accepted (simultaneous push/pop) and `occ` is unchanged.
- Empty condition: `occ`=0 gives `out_valid`=0, and `dout` holds its last value.
- `sel` and `din` are ignored when the beat is not accepted.

## Timing
- Latency: a beat accepted at edge n appears at the output (`out_valid`=1, `dout` valid) after edge n+DEPTH−1, provided there is no stall. With DEPTH=1, the output updates on the accept edge.
- Throughput is 1 beat/cycle with no stall.
- Occupancy bound: total occupancy ≤ DEPTH.
- Critical path: the `out_ready`→`in_ready` ready chain, which is DEPTH AND/OR levels deep.

## Configuration
- `SEL_PIPE_PARITY_EN` defined:
  - each stage carries an extra even-parity bit, computed at stage 0 over the captured value.
  - `par_err` = `out_valid` && (parity of `dout` ≠ carried bit). It is combinational and resets to 0.
- Undefined: no parity storage and no `par_err` port. Behaviour is otherwise identical.

## Structure
- `sel_pipe_pkg` contains:
  - `occ_w(depth)` function;
  - the default `FILL` constant;
  - a stage struct typedef `{logic v; logic [WIDTH-1:0] d; logic p;}`. The parity field `p` is guarded by the macro.
- Sub-module `sel_pipe_stage`: one valid/data register with load/hold/clear and an `adv` output. It is instantiated DEPTH times in a generate loop.
- Top level: capture mux, ready chain, occupancy counter.

## Test plan
1. Reset then streaming: reset low for 3 cycles → `dout`=0, `out_valid`=0, `occ`=0, and `in_ready`=1 after release. Then, with WIDTH=8, DEPTH=2, push `din`=0x5A with `sel`=1 → `dout`=0x5A with `out_valid` two edges later.
2. Fill select: `sel`=0, `din`=0x00 → `dout`=0xFF.
3. Back-to-back: 4 beats (0x01–0x04) with `out_ready` held 1 → outputs 0x01–0x04 on consecutive cycles with no bubbles.
4. Stall full: `out_ready`=0 and push 3 beats → after 2 accepts, `in_ready`=0 and `occ`=2, with `dout` frozen at the first beat. Raise `out_ready` → remaining beats emerge in order.
5. Simultaneous push/pop at full: `in_ready`=1, `occ` stays 2, and no beat is lost or duplicated.
6. Reset mid-stream: assert `reset` while `occ`=2 → `out_valid`=0, `dout`=0 immediately (async). After release, the next beat flows normally. With `SEL_PIPE_PARITY_EN`, forcing a flipped stored bit gives `par_err`=1.
